// File: rtl/aes_job_arbiter_if.sv
// Bundles the requester, AES-core and response buses of aes_job_arbiter.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs; core side has none (ld/done strobes).
// Ports: req0/req1 job handshakes with text/key, core load/done bus, response handshake.
interface aes_job_arbiter_if #(
    parameter int DW = 128
);
    // requester 0
    logic          req0_valid_i;
    logic          req0_ready_o;
    logic [DW-1:0] req0_text_i;
    logic [DW-1:0] req0_key_i;
    // requester 1
    logic          req1_valid_i;
    logic          req1_ready_o;
    logic [DW-1:0] req1_text_i;
    logic [DW-1:0] req1_key_i;
    // AES core
    logic          core_ld_o;
    logic [DW-1:0] core_text_o;
    logic [DW-1:0] core_key_o;
    logic          core_done_i;
    logic [DW-1:0] core_data_i;
    // response
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          rsp_id_o;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_err_o;

    // arbiter side
    modport slave (
        input  req0_valid_i, req0_text_i, req0_key_i,
        input  req1_valid_i, req1_text_i, req1_key_i,
        input  core_done_i, core_data_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output core_ld_o, core_text_o, core_key_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
    );

    // environment side (requesters, core and consumer)
    modport master (
        output req0_valid_i, req0_text_i, req0_key_i,
        output req1_valid_i, req1_text_i, req1_key_i,
        output core_done_i, core_data_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  core_ld_o, core_text_o, core_key_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters, with timeout watchdog.
// Latency: accept T, core_ld_o T+1, earliest done sampled T+2, rsp_valid_o T+3.
// Backpressure: one job in flight; requester ready only in IDLE; response held until rsp_ready_i.
// Ports: clk, rst (async active-low), bus (slave modport: req0/req1 jobs, core load/done,
//        tagged response), busy_o (high whenever a job is in flight).
module aes_job_arbiter #(
    parameter int DW      = 128,
    parameter int TIMEOUT = 63,
    parameter int TW      = 6
) (
    input  logic               clk,
    input  logic               rst,
    aes_job_arbiter_if.slave   bus,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic          id_q;
    logic [DW-1:0] text_q;
    logic [DW-1:0] key_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          core_ld_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;

    logic gnt0;
    logic gnt1;
    logic acc0;
    logic acc1;

    // With both requesting, the one not served last wins.
    assign gnt0 = bus.req0_valid_i & (~bus.req1_valid_i | last_grant_q);
    assign gnt1 = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant_q);
    assign acc0 = (state_q == ST_IDLE) & gnt0;
    assign acc1 = (state_q == ST_IDLE) & gnt1;

    // timer_d counts WAIT cycles including the current one; reaching TIMEOUT aborts.
    assign timer_d = timer_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            text_q       <= '0;
            key_q        <= '0;
            timer_q      <= '0;
            core_ld_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc0 || acc1) begin
                        text_q    <= acc1 ? bus.req1_text_i : bus.req0_text_i;
                        key_q     <= acc1 ? bus.req1_key_i  : bus.req0_key_i;
                        id_q      <= acc1;
                        core_ld_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // done is ignored here even if the core pulses it early.
                    core_ld_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_q <= timer_d;
                    if (bus.core_done_i) begin
                        // done beats a simultaneous timeout
                        rsp_data_q  <= bus.core_data_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (timer_d == TW'(TIMEOUT)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= id_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req0_ready_o = acc0;
    assign bus.req1_ready_o = acc1;
    assign bus.core_ld_o    = core_ld_q;
    assign bus.core_text_o  = text_q;
    assign bus.core_key_o   = key_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_id_o     = id_q;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.rsp_err_o    = rsp_err_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_job_arbiter.sv
module tb_aes_job_arbiter;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    aes_job_arbiter_if #(.DW(DW)) bus ();

    aes_job_arbiter #(.DW(DW), .TIMEOUT(63), .TW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected response and compares it with the DUT output.
    task automatic check_rsp(input string tag);
        rsp_t e;
        chk1({tag, "_rsp_valid"}, bus.rsp_valid_o, 1'b1);
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed response with empty scoreboard, expected none", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk1({tag, "_id"}, bus.rsp_id_o, e.id);
            chkw({tag, "_data"}, bus.rsp_data_o, e.data);
            chk1({tag, "_err"}, bus.rsp_err_o, e.err);
        end
    endtask

    // One job from requester r; delay = cycles from ld to done (-1 = never);
    // hold = cycles the consumer stalls the response.
    task automatic job(input int r, input logic [DW-1:0] txt, input logic [DW-1:0] k,
                       input logic [DW-1:0] res, input int delay, input int hold,
                       input string tag);
        rsp_t e;
        int   rc;
        rc     = (delay >= 0) ? delay + 1 : 64;
        e.id   = (r != 0);
        e.err  = (delay < 0);
        e.data = (delay < 0) ? '0 : res;
        sb.push_back(e);

        tick;
        bus.rsp_ready_i = (hold == 0);
        if (r == 0) begin
            bus.req0_valid_i = 1'b1; bus.req0_text_i = txt; bus.req0_key_i = k;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_text_i = txt; bus.req1_key_i = k;
        end
        #1;
        chk1({tag, "_accept_rdy"}, (r == 0) ? bus.req0_ready_o : bus.req1_ready_o, 1'b1);
        tick;   // ld cycle
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        bus.req0_text_i = ~txt;  bus.req1_text_i = ~txt;
        bus.req0_key_i  = ~k;    bus.req1_key_i  = ~k;
        chk1({tag, "_ld"}, bus.core_ld_o, 1'b1);
        chkw({tag, "_ld_text"}, bus.core_text_o, txt);
        chkw({tag, "_ld_key"}, bus.core_key_o, k);
        chk1({tag, "_busy"}, busy, 1'b1);
        for (int c = 1; c < rc; c++) begin
            tick;
            bus.core_done_i = (c == delay);
            bus.core_data_i = (c == delay) ? res : ~res;
            if (c == 1)      chk1({tag, "_ld_pulse"}, bus.core_ld_o, 1'b0);
            if (c == rc - 1) chk1({tag, "_early_rsp"}, bus.rsp_valid_o, 1'b0);
        end
        tick;
        bus.core_done_i = 1'b0;
        check_rsp(tag);
        if (hold > 0) begin
            bus.req0_valid_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick;
                chk1({tag, "_hold_valid"}, bus.rsp_valid_o, 1'b1);
                chk1({tag, "_hold_id"}, bus.rsp_id_o, e.id);
                chkw({tag, "_hold_data"}, bus.rsp_data_o, e.data);
                chk1({tag, "_hold_err"}, bus.rsp_err_o, e.err);
                chk1({tag, "_hold_busy"}, busy, 1'b1);
                chk1({tag, "_hold_rdy0"}, bus.req0_ready_o, 1'b0);
            end
            chkw({tag, "_hold_text"}, bus.core_text_o, txt);
            bus.rsp_ready_i = 1'b1;
            #1;
            chk1({tag, "_hs_rdy0"}, bus.req0_ready_o, 1'b0);
        end
        tick;
        chk1({tag, "_post_valid"}, bus.rsp_valid_o, 1'b0);
        chk1({tag, "_post_busy"}, busy, 1'b0);
        if (hold > 0) begin
            chk1({tag, "_idle_rdy0"}, bus.req0_ready_o, 1'b1);
            bus.req0_valid_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t0, k0, t1, k1, res;
        rsp_t          e;
        bit            found;
        bit            seen;

        rst = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req0_text_i = '0; bus.req0_key_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_text_i = '0; bus.req1_key_i = '0;
        bus.core_done_i = 1'b0;  bus.core_data_i = '0; bus.rsp_ready_i = 1'b0;
        repeat (2) tick;
        chk1("rst_ld", bus.core_ld_o, 1'b0);
        chk1("rst_valid", bus.rsp_valid_o, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_id", bus.rsp_id_o, 1'b0);
        chkw("rst_data", bus.rsp_data_o, '0);
        chk1("rst_err", bus.rsp_err_o, 1'b0);
        chkw("rst_text", bus.core_text_o, '0);
        chkw("rst_key", bus.core_key_o, '0);
        rst = 1'b1;

        job(0, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f,
            128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 10, 0, "single");
        job(0, 128'hdead0000_0000beef_11111111_22222222, 128'h33333333_44444444_55555555_66666666,
            128'h0, -1, 0, "timeout");
        job(1, 128'hcafe0001_cafe0002_cafe0003_cafe0004, 128'hf00d0001_f00d0002_f00d0003_f00d0004,
            128'h12345678_9abcdef0_0fedcba9_87654321, 5, 0, "after_to");
        job(1, 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a, 128'h01234567_89abcdef_01234567_89abcdef,
            128'h77777777_88888888_99999999_aaaaaaaa, 63, 0, "done_at_to");
        job(0, 128'h10101010_20202020_30303030_40404040, 128'h50505050_60606060_70707070_80808080,
            128'hfedcba98_76543210_fedcba98_76543210, 2, 20, "hold");

        // reset in the middle of WAIT, then a stale done
        tick;
        bus.rsp_ready_i = 1'b1;
        bus.req0_valid_i = 1'b1;
        bus.req0_text_i = 128'h1; bus.req0_key_i = 128'h2;
        tick;
        bus.req0_valid_i = 1'b0;
        chk1("mrst_ld", bus.core_ld_o, 1'b1);
        repeat (5) tick;
        rst = 1'b0;
        #1;
        chk1("mrst_ld0", bus.core_ld_o, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_valid", bus.rsp_valid_o, 1'b0);
        chkw("mrst_text", bus.core_text_o, '0);
        chkw("mrst_key", bus.core_key_o, '0);
        tick;
        rst = 1'b1;
        tick;
        bus.core_done_i = 1'b1; bus.core_data_i = 128'h99;
        tick;
        bus.core_done_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid_o || busy) seen = 1'b1;
            tick;
        end
        chk1("mrst_no_rsp", seen, 1'b0);
        job(1, 128'h0badf00d_0badf00d_0badf00d_0badf00d, 128'h1eaf1eaf_1eaf1eaf_1eaf1eaf_1eaf1eaf,
            128'h31415926_53589793_23846264_33832795, 4, 0, "post_rst");

        // round robin with both requesters always valid
        t0 = 128'h0aaa0aaa_0aaa0aaa_0aaa0aaa_0aaa0aaa; k0 = 128'h0bbb0bbb_0bbb0bbb_0bbb0bbb_0bbb0bbb;
        t1 = 128'h1ccc1ccc_1ccc1ccc_1ccc1ccc_1ccc1ccc; k1 = 128'h1ddd1ddd_1ddd1ddd_1ddd1ddd_1ddd1ddd;
        tick;
        bus.rsp_ready_i = 1'b1;
        bus.req0_valid_i = 1'b1; bus.req0_text_i = t0; bus.req0_key_i = k0;
        bus.req1_valid_i = 1'b1; bus.req1_text_i = t1; bus.req1_key_i = k1;
        #1;
        chk1("rr_first_rdy0", bus.req0_ready_o, 1'b1);
        chk1("rr_first_rdy1", bus.req1_ready_o, 1'b0);
        for (int j = 0; j < 4; j++) begin
            found = 1'b0;
            for (int w = 0; w < 10 && !found; w++) begin
                tick;
                if (bus.core_ld_o) found = 1'b1;
            end
            chk1("rr_ld_seen", found, 1'b1);
            chkw("rr_text", bus.core_text_o, (j % 2 == 1) ? t1 : t0);
            chkw("rr_key", bus.core_key_o, (j % 2 == 1) ? k1 : k0);
            res = {4{32'h5000_0000 + 32'(j)}};
            e.id = (j % 2 == 1); e.data = res; e.err = 1'b0;
            sb.push_back(e);
            repeat (3) tick;
            bus.core_done_i = 1'b1; bus.core_data_i = res;
            tick;
            bus.core_done_i = 1'b0;
            check_rsp("rr");
        end
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        tick;
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain: observed %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
